// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

    localparam int SCORE_W = 4;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    typedef enum logic [2:0] {
        SERVE       = 3'd0,
        RALLY       = 3'd1,
        POINT_PAUSE = 3'd2,
        GAME_OVER   = 3'd3
    } state_t;

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable 8-bit frame_tick down-counter. A load wins over a coincident tick;
// done flags the tick that takes the count from one to zero, where it then rests.
module pong_frame_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       active,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active = (count_q != 8'd0);
    assign done   = tick && (count_q == 8'd1);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/pause/game-over FSM, scores, serve side and beeps.
// Define AUTO_SERVE_EN to take the serve automatically after SERVE_TIMEOUT frames.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE     = 9,
    parameter int PAUSE_FRAMES  = 60,
    parameter int BEEP_FRAMES   = 6,
    parameter int SERVE_TIMEOUT = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       p1_srv,
    input  logic       p2_srv,
    input  logic       start,
    input  logic       goal_l,
    input  logic       goal_r,
    input  logic       paddle_hit,
    input  logic       wall_hit,
    output logic       ball_run,
    output logic       ball_load,
    output logic       serve_side,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic       beep_low,
    output logic       beep_high,
    output logic [2:0] state
);

    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         PAUSE_VAL = 8'(PAUSE_FRAMES);
    localparam logic [7:0]         BEEP_VAL  = 8'(BEEP_FRAMES);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               serve_side_q, serve_side_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_load_q, ball_load_d;
    logic               winner_q, winner_d;
    logic               p1_srv_q, p1_srv_d, p1_prev_q, p1_prev_d;
    logic               p2_srv_q, p2_srv_d, p2_prev_q, p2_prev_d;
    logic               start_q, start_d, start_prev_q, start_prev_d;

    logic       p1_rise, p2_rise, start_rise, serve_press, auto_fire;
    logic       pause_load, pause_done;
    logic       low_load, high_load;
    logic [7:0] low_val;
    logic       low_active, high_active;
    logic       unused_pause_active, unused_low_done, unused_high_done;

    // Raw buttons pass one register stage before edge detection.
    assign p1_rise    = p1_srv_q && !p1_prev_q;
    assign p2_rise    = p2_srv_q && !p2_prev_q;
    assign start_rise = start_q && !start_prev_q;

    always_comb begin
        state_d      = state_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        serve_side_d = serve_side_q;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        ball_load_d  = 1'b0;
        p1_srv_d     = p1_srv;
        p1_prev_d    = p1_srv_q;
        p2_srv_d     = p2_srv;
        p2_prev_d    = p2_srv_q;
        start_d      = start;
        start_prev_d = start_q;
        pause_load   = 1'b0;
        low_load     = 1'b0;
        low_val      = BEEP_VAL;
        high_load    = 1'b0;
        serve_press  = (serve_side_q == SIDE_P2) ? p2_rise : p1_rise;

        case (state_q)
            SERVE: begin
                if (serve_press || auto_fire) begin
                    state_d     = RALLY;
                    serve_dir_d = serve_side_q;
                end
            end
            RALLY: begin
                // goal_l is checked first so it wins a same-cycle double goal.
                if (goal_l || goal_r) begin
                    if (goal_l) begin
                        if (score2_q != WIN) score2_d = score2_q + 1'b1;
                        serve_side_d = SIDE_P1;
                    end else begin
                        if (score1_q != WIN) score1_d = score1_q + 1'b1;
                        serve_side_d = SIDE_P2;
                    end
                    high_load  = 1'b1;
                    low_load   = 1'b1;
                    low_val    = 8'd0;
                    pause_load = 1'b1;
                    state_d    = POINT_PAUSE;
                end else if (paddle_hit || wall_hit) begin
                    low_load = 1'b1;
                end
            end
            POINT_PAUSE: begin
                if (pause_done) begin
                    ball_load_d = 1'b1;
                    if ((score1_q == WIN) || (score2_q == WIN)) begin
                        state_d  = GAME_OVER;
                        winner_d = (score2_q == WIN);
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    score1_d     = '0;
                    score2_d     = '0;
                    ball_load_d  = 1'b1;
                    serve_side_d = SIDE_P2;
                    state_d      = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SERVE;
            score1_q     <= '0;
            score2_q     <= '0;
            serve_side_q <= SIDE_P2;
            serve_dir_q  <= 1'b1;
            ball_load_q  <= 1'b0;
            winner_q     <= 1'b0;
            p1_srv_q     <= 1'b0;
            p1_prev_q    <= 1'b0;
            p2_srv_q     <= 1'b0;
            p2_prev_q    <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            serve_side_q <= serve_side_d;
            serve_dir_q  <= serve_dir_d;
            ball_load_q  <= ball_load_d;
            winner_q     <= winner_d;
            p1_srv_q     <= p1_srv_d;
            p1_prev_q    <= p1_prev_d;
            p2_srv_q     <= p2_srv_d;
            p2_prev_q    <= p2_prev_d;
            start_q      <= start_d;
            start_prev_q <= start_prev_d;
        end
    end

    pong_frame_timer u_pause_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .load     (pause_load),
        .load_val (PAUSE_VAL),
        .active   (unused_pause_active),
        .done     (pause_done)
    );

    pong_frame_timer u_beep_low_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .load     (low_load),
        .load_val (low_val),
        .active   (low_active),
        .done     (unused_low_done)
    );

    pong_frame_timer u_beep_high_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .load     (high_load),
        .load_val (BEEP_VAL),
        .active   (high_active),
        .done     (unused_high_done)
    );

`ifdef AUTO_SERVE_EN
    logic       serve_load;
    logic [7:0] serve_val;
    logic       serve_active;

    // Reload on entry to SERVE (and on the first SERVE cycle after reset); zero on exit.
    always_comb begin
        serve_val  = (state_d == SERVE) ? 8'(SERVE_TIMEOUT) : 8'd0;
        serve_load = (state_d == SERVE) ? ((state_q != SERVE) || !serve_active)
                                        : (state_q == SERVE);
    end

    pong_frame_timer u_serve_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .load     (serve_load),
        .load_val (serve_val),
        .active   (serve_active),
        .done     (auto_fire)
    );
`else
    logic [7:0] unused_serve_timeout;
    assign unused_serve_timeout = 8'(SERVE_TIMEOUT);
    assign auto_fire            = 1'b0;
`endif

    assign ball_run   = (state_q == RALLY);
    assign game_over  = (state_q == GAME_OVER);
    assign ball_load  = ball_load_q;
    assign serve_side = serve_side_q;
    assign serve_dir  = serve_dir_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign winner     = winner_q;
    assign beep_low   = low_active;
    assign beep_high  = high_active;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed vector table, hand-written
// match sequences and randomized traffic against a behavioural match model.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int WIN   = 3;
    localparam int PAUSE = 4;
    localparam int BEEP  = 3;
    localparam int STO   = 5;

    localparam int PH_SERVE = 0;
    localparam int PH_RALLY = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_OVER  = 3;

    typedef struct packed {
        logic p1, p2, st, gl, gr, ph, wh, tick;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       run;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       side, blow, bhigh, load;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, frame_tick, p1_srv, p2_srv, start, goal_l, goal_r, paddle_hit, wall_hit;
    logic ball_run, ball_load, serve_side, serve_dir, game_over, winner, beep_low, beep_high;
    logic [3:0] score1, score2;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    // Behavioural model: match phase, scores and frames left on each timer.
    int         m_phase, m_s1, m_s2, m_pause, m_blow, m_bhigh;
    logic       m_side, m_dir, m_load, m_winner;
    logic [1:0] m_p1h, m_p2h, m_sth;
`ifdef AUTO_SERVE_EN
    int         m_sto;
`endif

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE     (WIN),
        .PAUSE_FRAMES  (PAUSE),
        .BEEP_FRAMES   (BEEP),
        .SERVE_TIMEOUT (STO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .p1_srv     (p1_srv),
        .p2_srv     (p2_srv),
        .start      (start),
        .goal_l     (goal_l),
        .goal_r     (goal_r),
        .paddle_hit (paddle_hit),
        .wall_hit   (wall_hit),
        .ball_run   (ball_run),
        .ball_load  (ball_load),
        .serve_side (serve_side),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over),
        .winner     (winner),
        .beep_low   (beep_low),
        .beep_high  (beep_high),
        .state      (state)
    );

    function automatic vec_t mkVec(int in, int run, int s1, int s2, int side,
                                   int blow, int bhigh, int load);
        vec_t v;
        v.s     = stim_t'(8'(in));
        v.run   = 1'(run);
        v.s1    = 4'(s1);
        v.s2    = 4'(s2);
        v.side  = 1'(side);
        v.blow  = 1'(blow);
        v.bhigh = 1'(bhigh);
        v.load  = 1'(load);
        return v;
    endfunction

    function automatic logic [2:0] expState(int ph);
        case (ph)
            PH_RALLY: return RALLY;
            PH_PAUSE: return POINT_PAUSE;
            PH_OVER:  return GAME_OVER;
            default:  return SERVE;
        endcase
    endfunction

    task automatic modelReset();
        m_phase  = PH_SERVE;
        m_s1     = 0;
        m_s2     = 0;
        m_pause  = 0;
        m_blow   = 0;
        m_bhigh  = 0;
        m_side   = 1'b1;
        m_dir    = 1'b1;
        m_load   = 1'b0;
        m_winner = 1'b0;
        m_p1h    = 2'b00;
        m_p2h    = 2'b00;
        m_sth    = 2'b00;
`ifdef AUTO_SERVE_EN
        m_sto    = 0;
`endif
    endtask

    // One clock of the match rules; reloads of a timer override a coincident tick.
    task automatic modelStep(input stim_t s, input logic rn);
        logic p1r, p2r, str, pauseDone, autoFire;
        int   prevPhase;
        if (!rn) begin
            modelReset();
        end else begin
            p1r       = m_p1h[0] && !m_p1h[1];
            p2r       = m_p2h[0] && !m_p2h[1];
            str       = m_sth[0] && !m_sth[1];
            pauseDone = s.tick && (m_pause == 1);
            autoFire  = 1'b0;
`ifdef AUTO_SERVE_EN
            autoFire  = (m_phase == PH_SERVE) && s.tick && (m_sto == 1);
`endif
            if (s.tick && m_pause > 0) m_pause--;
            if (s.tick && m_blow > 0)  m_blow--;
            if (s.tick && m_bhigh > 0) m_bhigh--;
            m_load    = 1'b0;
            prevPhase = m_phase;
            case (m_phase)
                PH_SERVE: begin
                    if ((m_side ? p2r : p1r) || autoFire) begin
                        m_phase = PH_RALLY;
                        m_dir   = m_side;
                    end
                end
                PH_RALLY: begin
                    if (s.gl || s.gr) begin
                        if (s.gl) begin
                            if (m_s2 < WIN) m_s2++;
                            m_side = 1'b0;
                        end else begin
                            if (m_s1 < WIN) m_s1++;
                            m_side = 1'b1;
                        end
                        m_bhigh = BEEP;
                        m_blow  = 0;
                        m_pause = PAUSE;
                        m_phase = PH_PAUSE;
                    end else if (s.ph || s.wh) begin
                        m_blow = BEEP;
                    end
                end
                PH_PAUSE: begin
                    if (pauseDone) begin
                        m_load = 1'b1;
                        if (m_s1 == WIN || m_s2 == WIN) begin
                            m_phase  = PH_OVER;
                            m_winner = (m_s2 == WIN);
                        end else begin
                            m_phase = PH_SERVE;
                        end
                    end
                end
                default: begin
                    if (str) begin
                        m_s1    = 0;
                        m_s2    = 0;
                        m_load  = 1'b1;
                        m_side  = 1'b1;
                        m_phase = PH_SERVE;
                    end
                end
            endcase
`ifdef AUTO_SERVE_EN
            if (m_phase == PH_SERVE) begin
                if (prevPhase != PH_SERVE || m_sto == 0) m_sto = STO;
                else if (s.tick) m_sto--;
            end else begin
                m_sto = 0;
            end
`else
            prevPhase = prevPhase + 0;
`endif
            m_p1h = {m_p1h[0], s.p1};
            m_p2h = {m_p2h[0], s.p2};
            m_sth = {m_sth[0], s.st};
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("ball_run",   32'(ball_run),   32'(m_phase == PH_RALLY));
        checkValue("ball_load",  32'(ball_load),  32'(m_load));
        checkValue("serve_side", 32'(serve_side), 32'(m_side));
        checkValue("serve_dir",  32'(serve_dir),  32'(m_dir));
        checkValue("score1",     32'(score1),     32'(m_s1));
        checkValue("score2",     32'(score2),     32'(m_s2));
        checkValue("game_over",  32'(game_over),  32'(m_phase == PH_OVER));
        checkValue("winner",     32'(winner),     32'(m_winner));
        checkValue("beep_low",   32'(beep_low),   32'(m_blow > 0));
        checkValue("beep_high",  32'(beep_high),  32'(m_bhigh > 0));
        checkValue("state",      32'(state),      32'(expState(m_phase)));
    endtask

    // Drive on the falling edge, advance the model on the rising edge, compare just after.
    task automatic applyStimulus(input stim_t s, input logic rn);
        @(negedge clk);
        rst_n      = rn;
        p1_srv     = s.p1;
        p2_srv     = s.p2;
        start      = s.st;
        goal_l     = s.gl;
        goal_r     = s.gr;
        paddle_hit = s.ph;
        wall_hit   = s.wh;
        frame_tick = s.tick;
        @(posedge clk);
        modelStep(s, rn);
        cycle++;
        #1;
        checkOutput();
    endtask

    task automatic serveBall();
        stim_t s;
        s = '0;
        if (m_side) s.p2 = 1'b1;
        else        s.p1 = 1'b1;
        applyStimulus(s, 1'b1);
        applyStimulus(s, 1'b1);
        applyStimulus(stim_t'(8'h00), 1'b1);
        checkValue("serve reaches rally", 32'(ball_run), 32'd1);
    endtask

    task automatic playPoint(input logic leftGoal);
        stim_t s;
        int    budget;
        serveBall();
        s    = '0;
        s.gl = leftGoal;
        s.gr = !leftGoal;
        applyStimulus(s, 1'b1);
        s      = '0;
        s.tick = 1'b1;
        budget = 3 * PAUSE;
        while (ball_load !== 1'b1 && budget > 0) begin
            applyStimulus(s, 1'b1);
            budget--;
        end
        checkValue("pause ends with ball_load", 32'(ball_load), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t  vecs[18];
        stim_t idle;
        stim_t s;
        logic  lp1, lp2, lst;
        int    ticks;

        vecs[0]  = mkVec('b1000_0000, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mkVec('b1000_0000, 0, 0, 0, 1, 0, 0, 0);
        vecs[2]  = mkVec('b0100_0000, 0, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mkVec('b0100_0000, 1, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mkVec('b0000_0100, 1, 0, 0, 1, 1, 0, 0);
        vecs[5]  = mkVec('b0000_0001, 1, 0, 0, 1, 1, 0, 0);
        vecs[6]  = mkVec('b0000_0001, 1, 0, 0, 1, 1, 0, 0);
        vecs[7]  = mkVec('b0000_0011, 1, 0, 0, 1, 1, 0, 0);
        vecs[8]  = mkVec('b0000_1100, 0, 1, 0, 1, 0, 1, 0);
        vecs[9]  = mkVec('b0000_0001, 0, 1, 0, 1, 0, 1, 0);
        vecs[10] = mkVec('b0000_0001, 0, 1, 0, 1, 0, 1, 0);
        vecs[11] = mkVec('b0000_0001, 0, 1, 0, 1, 0, 0, 0);
        vecs[12] = mkVec('b0001_0000, 0, 1, 0, 1, 0, 0, 0);
        vecs[13] = mkVec('b0000_0001, 0, 1, 0, 1, 0, 0, 1);
        vecs[14] = mkVec('b0000_0000, 0, 1, 0, 1, 0, 0, 0);
        vecs[15] = mkVec('b0100_0000, 0, 1, 0, 1, 0, 0, 0);
        vecs[16] = mkVec('b0100_0000, 1, 1, 0, 1, 0, 0, 0);
        vecs[17] = mkVec('b0001_1000, 0, 1, 1, 0, 0, 1, 0);

        idle       = '0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        p1_srv     = 1'b0;
        p2_srv     = 1'b0;
        start      = 1'b0;
        goal_l     = 1'b0;
        goal_r     = 1'b0;
        paddle_hit = 1'b0;
        wall_hit   = 1'b0;
        modelReset();

        // Reset state.
        applyStimulus(idle, 1'b0);
        applyStimulus(idle, 1'b0);
        checkValue("reset state",      32'(state),      32'(SERVE));
        checkValue("reset serve_side", 32'(serve_side), 32'd1);
        checkValue("reset serve_dir",  32'(serve_dir),  32'd1);

        // Directed vector table from reset.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].s, 1'b1);
            checkValue($sformatf("vec%0d outputs", i),
                       32'({ball_run, score1, score2, serve_side, beep_low, beep_high, ball_load}),
                       32'({vecs[i].run, vecs[i].s1, vecs[i].s2, vecs[i].side,
                            vecs[i].blow, vecs[i].bhigh, vecs[i].load}));
        end

        // P2 wins a full match, then a start rise restarts it.
        applyStimulus(idle, 1'b0);
        playPoint(1'b1);
        playPoint(1'b1);
        playPoint(1'b1);
        checkValue("match game_over", 32'(game_over), 32'd1);
        checkValue("match winner",    32'(winner),    32'd1);
        checkValue("match score2",    32'(score2),    32'(WIN));
        checkValue("match state",     32'(state),     32'(GAME_OVER));
        s    = '0;
        s.st = 1'b1;
        applyStimulus(s, 1'b1);
        applyStimulus(s, 1'b1);
        checkValue("restart scores",    32'({score1, score2}), 32'd0);
        checkValue("restart state",     32'(state),            32'(SERVE));
        checkValue("restart ball_load", 32'(ball_load),        32'd1);
        checkValue("restart side",      32'(serve_side),       32'd1);
        applyStimulus(idle, 1'b1);

        // Reset asserted in the middle of a rally with a live beep.
        playPoint(1'b0);
        playPoint(1'b0);
        serveBall();
        s    = '0;
        s.ph = 1'b1;
        applyStimulus(s, 1'b1);
        checkValue("pre-reset score1", 32'(score1), 32'd2);
        applyStimulus(idle, 1'b0);
        checkValue("mid-rally reset outputs",
                   32'({state, ball_run, ball_load, serve_side, serve_dir, score1, score2,
                        game_over, winner, beep_low, beep_high}),
                   32'({SERVE, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}));

        // Serving with no buttons pressed.
        applyStimulus(idle, 1'b1);
        s      = '0;
        s.tick = 1'b1;
        ticks  = 0;
`ifdef AUTO_SERVE_EN
        while (ball_run !== 1'b1 && ticks < 4 * STO) begin
            applyStimulus(s, 1'b1);
            ticks++;
        end
        checkValue("auto-serve tick count", 32'(ticks), 32'(STO));
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(s, 1'b1);
            ticks++;
        end
        checkValue("no auto-serve ball_run", 32'(ball_run), 32'd0);
        checkValue("no auto-serve state",    32'(state),    32'(SERVE));
`endif

        // Randomized traffic against the model.
        lp1 = 1'b0;
        lp2 = 1'b0;
        lst = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)  lp1 = !lp1;
            if ($urandom_range(0, 7) == 0)  lp2 = !lp2;
            if ($urandom_range(0, 15) == 0) lst = !lst;
            s.p1   = lp1;
            s.p2   = lp2;
            s.st   = lst;
            s.gl   = ($urandom_range(0, 19) == 0);
            s.gr   = ($urandom_range(0, 19) == 0);
            s.ph   = ($urandom_range(0, 9) == 0);
            s.wh   = ($urandom_range(0, 9) == 0);
            s.tick = ($urandom_range(0, 2) == 0);
            applyStimulus(s, ($urandom_range(0, 399) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
